// File: rtl/fetch_stage_pkg.sv
// Shared widths, constants and payload types for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST   = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] INST_BYTES = XLEN'(4);

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic            IMEM_req;
    logic [XLEN-1:0] IMEM_addr;
    logic            IMEM_gnt;
    logic            IMEM_rvalid;
    logic [XLEN-1:0] IMEM_rdata;

    modport master (output IMEM_req, IMEM_addr, input IMEM_gnt, IMEM_rvalid, IMEM_rdata);
    modport slave  (input IMEM_req, IMEM_addr, output IMEM_gnt, IMEM_rvalid, IMEM_rdata);
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a returned instruction while IF/ID is stalled.
module fetch_skid_buf
    import fetch_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en_i,
    input  fetch_entry_t wr_data_i,
    input  logic         rd_en_i,
    input  logic         flush_i,
    output logic         valid_o,
    output fetch_entry_t data_o
);

    logic         valid_q, valid_d;
    fetch_entry_t data_q, data_d;

    // Flush beats write; a write in the same cycle as a read refills the entry.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (wr_en_i) begin
            valid_d = 1'b1;
            data_d  = wr_data_i;
        end else if (rd_en_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues one outstanding imem request at a time and
// loads IF/ID, parking a returned word in a skid entry when IF/ID is stalled.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ST_if_id_en,
    input  logic            EX_take_branch,
    input  logic [XLEN-1:0] EX_target_pc,
    fetch_stage_if.master   imem,
    output logic [XLEN-1:0] IF_ID_inst,
    output logic [XLEN-1:0] IF_ID_PC,
    output logic [XLEN-1:0] IF_ID_NPC,
    output logic            IF_ID_valid
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fl_pc_q, fl_pc_d;
    logic            outstanding_q, outstanding_d;
    logic            squash_q, squash_d;
    logic [XLEN-1:0] ifid_inst_q, ifid_inst_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0] ifid_npc_q, ifid_npc_d;
    logic            ifid_valid_q, ifid_valid_d;

    logic         sk_valid, sk_wr, sk_rd, sk_flush;
    fetch_entry_t sk_rdata, sk_wdata;
    logic         rv_any_c, rv_live_c, req_c, grant_c;

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (sk_wr),
        .wr_data_i (sk_wdata),
        .rd_en_i   (sk_rd),
        .flush_i   (sk_flush),
        .valid_o   (sk_valid),
        .data_o    (sk_rdata)
    );

    // Only a response to our own in-flight request counts; squashed ones are dropped.
    assign rv_any_c  = imem.IMEM_rvalid && outstanding_q;
    assign rv_live_c = rv_any_c && !squash_q;

    // A stalled return fills the skid, so no new request may race in behind it.
    assign req_c = rst && !EX_take_branch && !sk_valid
                && (!outstanding_q || rv_any_c)
                && !(rv_live_c && !ST_if_id_en);
    assign grant_c = req_c && imem.IMEM_gnt;

    assign imem.IMEM_req  = req_c;
    assign imem.IMEM_addr = pc_q;

    always_comb begin
        pc_d          = pc_q;
        fl_pc_d       = fl_pc_q;
        outstanding_d = outstanding_q;
        squash_d      = squash_q;
        ifid_inst_d   = ifid_inst_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_npc_d    = ifid_npc_q;
        ifid_valid_d  = ifid_valid_q;
        sk_wr         = 1'b0;
        sk_rd         = 1'b0;
        sk_flush      = 1'b0;
        sk_wdata      = '{inst: imem.IMEM_rdata, pc: fl_pc_q};

        if (grant_c) begin
            pc_d          = next_pc(pc_q);
            fl_pc_d       = pc_q;
            outstanding_d = 1'b1;
        end else if (rv_any_c) begin
            outstanding_d = 1'b0;
        end
        if (rv_any_c) squash_d = 1'b0;

        if (EX_take_branch) begin
            pc_d         = EX_target_pc;
            sk_flush     = 1'b1;
            ifid_valid_d = 1'b0;
            ifid_inst_d  = NOP_INST;
            if (outstanding_q && !imem.IMEM_rvalid) squash_d = 1'b1;
        end else if (ST_if_id_en) begin
            if (sk_valid) begin
                ifid_valid_d = 1'b1;
                ifid_inst_d  = sk_rdata.inst;
                ifid_pc_d    = sk_rdata.pc;
                ifid_npc_d   = next_pc(sk_rdata.pc);
                sk_rd        = 1'b1;
                sk_wr        = rv_live_c;
            end else if (rv_live_c) begin
                ifid_valid_d = 1'b1;
                ifid_inst_d  = imem.IMEM_rdata;
                ifid_pc_d    = fl_pc_q;
                ifid_npc_d   = next_pc(fl_pc_q);
            end else begin
                ifid_valid_d = 1'b0;
                ifid_inst_d  = NOP_INST;
            end
        end else begin
            sk_wr = rv_live_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            fl_pc_q       <= '0;
            outstanding_q <= 1'b0;
            squash_q      <= 1'b0;
            ifid_inst_q   <= NOP_INST;
            ifid_pc_q     <= '0;
            ifid_npc_q    <= '0;
            ifid_valid_q  <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            fl_pc_q       <= fl_pc_d;
            outstanding_q <= outstanding_d;
            squash_q      <= squash_d;
            ifid_inst_q   <= ifid_inst_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_npc_q    <= ifid_npc_d;
            ifid_valid_q  <= ifid_valid_d;
        end
    end

    assign IF_ID_inst  = ifid_inst_q;
    assign IF_ID_PC    = ifid_pc_q;
    assign IF_ID_NPC   = ifid_npc_q;
    assign IF_ID_valid = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle-exact vector table, directed corner sequences and
// random traffic checked against an in-order instruction-stream model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_en, ex_br;
    logic [31:0] ex_tgt;
    logic [31:0] if_inst, if_pc, if_npc;
    logic        if_valid;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst_n),
        .ST_if_id_en    (st_en),
        .EX_take_branch (ex_br),
        .EX_target_pc   (ex_tgt),
        .imem           (bus),
        .IF_ID_inst     (if_inst),
        .IF_ID_PC       (if_pc),
        .IF_ID_NPC      (if_npc),
        .IF_ID_valid    (if_valid)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // memory model: at most one pending response
    int          cyc = 0;
    int          gnt_pct = 100;
    int          lat_min = 1, lat_max = 1;
    bit          pend = 1'b0;
    logic [31:0] pend_addr;
    int          pend_due;

    // last sampled bus values
    logic        s_req, s_grant, prev_req, prev_gnt;
    logic [31:0] s_addr, prev_addr;

    // stream model: next PC that must appear in IF/ID, and the expected IF/ID contents
    logic [31:0] exp_next;
    logic        m_valid;
    logic [31:0] m_inst, m_pc, m_npc;
    int          loads = 0;

    typedef struct {
        logic        en;
        logic        br;
        logic [31:0] tgt;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_npc;
    } vec_t;
    vec_t vecs[14];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_check(input logic en_v, input logic br_v, input logic [31:0] tgt_v);
        if (br_v) begin
            m_valid  = 1'b0;
            m_inst   = NOP_INST;
            exp_next = tgt_v;
        end else if (en_v) begin
            if (if_valid === 1'b1) begin
                m_valid  = 1'b1;
                m_pc     = exp_next;
                m_inst   = mem_word(exp_next);
                m_npc    = exp_next + 32'd4;
                exp_next = exp_next + 32'd4;
                loads++;
            end else begin
                m_valid = 1'b0;
                m_inst  = NOP_INST;
            end
        end
        chk("ifid_valid", 32'(if_valid), 32'(m_valid));
        chk("ifid_pc", if_pc, m_pc);
        chk("ifid_npc", if_npc, m_npc);
        chk("ifid_inst", if_inst, m_inst);
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input logic en_v, input logic br_v, input logic [31:0] tgt_v);
        logic rv, g;
        st_en  = en_v;
        ex_br  = br_v;
        ex_tgt = tgt_v;
        g  = (int'($urandom_range(99)) < gnt_pct);
        rv = pend && (pend_due <= cyc);
        bus.IMEM_gnt    = g;
        bus.IMEM_rvalid = rv;
        bus.IMEM_rdata  = rv ? mem_word(pend_addr) : $urandom();
        #1;
        s_req   = bus.IMEM_req;
        s_addr  = bus.IMEM_addr;
        s_grant = s_req && g;
        if (prev_req && !prev_gnt && s_req) chk("addr_stable", s_addr, prev_addr);
        if (s_grant) chk("one_outstanding", 32'(pend && !rv), 32'd0);
        @(posedge clk);
        cyc++;
        if (rv) pend = 1'b0;
        if (s_grant) begin
            pend      = 1'b1;
            pend_addr = s_addr;
            pend_due  = cyc + int'($urandom_range(lat_max, lat_min)) - 1;
        end
        prev_req  = s_req;
        prev_gnt  = g;
        prev_addr = s_addr;
        @(negedge clk);
        model_check(en_v, br_v, tgt_v);
    endtask

    // Asynchronous reset taken between clock edges; memory is reset alongside.
    task automatic apply_reset(input bit check_now);
        #2 rst_n = 1'b0;
        #1;
        if (check_now) begin
            chk("rst_valid", 32'(if_valid), 32'd0);
            chk("rst_inst", if_inst, NOP_INST);
            chk("rst_pc", if_pc, 32'd0);
            chk("rst_npc", if_npc, 32'd0);
            chk("rst_req", 32'(bus.IMEM_req), 32'd0);
        end
        st_en = 1'b1; ex_br = 1'b0; ex_tgt = '0;
        bus.IMEM_gnt = 1'b0; bus.IMEM_rvalid = 1'b0; bus.IMEM_rdata = '0;
        pend = 1'b0; prev_req = 1'b0; prev_gnt = 1'b0; prev_addr = '0;
        m_valid = 1'b0; m_inst = NOP_INST; m_pc = '0; m_npc = '0;
        exp_next = 32'h0000_0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int  l0;
        bit  found, got;
        logic [31:0] hold_addr;

        // zero-wait stream, 3-cycle stall at 0x8, redirect to 0x100 with rvalid + stall
        vecs[0]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000, 32'h000};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h004, 1'b1, 32'h000, 32'h004};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h004, 32'h008};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h008, 32'h00C};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h008, 32'h00C};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h008, 32'h00C};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h008, 32'h00C};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h00C, 32'h010};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h010, 1'b0, 32'h00C, 32'h010};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h014, 1'b1, 32'h010, 32'h014};
        vecs[10] = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h000, 1'b0, 32'h010, 32'h014};
        vecs[11] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h010, 32'h014};
        vecs[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100, 32'h104};
        vecs[13] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h104, 32'h108};

        @(negedge clk);
        apply_reset(1'b1);

        gnt_pct = 100; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].en, vecs[i].br, vecs[i].tgt);
            chk($sformatf("tbl%0d_req", i), 32'(s_req), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req) chk($sformatf("tbl%0d_addr", i), s_addr, vecs[i].exp_addr);
            chk($sformatf("tbl%0d_valid", i), 32'(if_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("tbl%0d_pc", i), if_pc, vecs[i].exp_pc);
            chk($sformatf("tbl%0d_npc", i), if_npc, vecs[i].exp_npc);
            chk($sformatf("tbl%0d_inst", i), if_inst,
                vecs[i].exp_valid ? mem_word(vecs[i].exp_pc) : NOP_INST);
        end

        // grant held low for 4 cycles: request stays up on a frozen address
        gnt_pct = 0;
        step(1'b1, 1'b0, '0);
        hold_addr = s_addr;
        chk("gntlow_req0", 32'(s_req), 32'd1);
        for (int k = 1; k < 4; k++) begin
            step(1'b1, 1'b0, '0);
            chk($sformatf("gntlow_req%0d", k), 32'(s_req), 32'd1);
            chk($sformatf("gntlow_addr%0d", k), s_addr, hold_addr);
        end
        gnt_pct = 100;
        l0 = loads;
        repeat (8) step(1'b1, 1'b0, '0);
        chk("gntlow_resume", 32'(loads - l0 >= 4), 32'd1);

        // latency 3: redirect while the fetch of 0x10 is in flight
        @(negedge clk);
        apply_reset(1'b0);
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            step(1'b1, 1'b0, '0);
            if (s_grant && s_addr == 32'h10) found = 1'b1;
        end
        chk("grant_0x10_seen", 32'(found), 32'd1);
        if (found) begin
            step(1'b1, 1'b1, 32'h100);
            got = 1'b0;
            for (int k = 0; k < 30 && !got; k++) begin
                step(1'b1, 1'b0, '0);
                if (if_valid === 1'b1) got = 1'b1;
            end
            chk("redir_load_seen", 32'(got), 32'd1);
            if (got) chk("redir_first_pc", if_pc, 32'h100);
        end

        // asynchronous reset in the middle of a stream
        lat_min = 1; lat_max = 2;
        repeat (10) step(1'b1, 1'b0, '0);
        apply_reset(1'b1);
        lat_min = 1; lat_max = 1;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            step(1'b1, 1'b0, '0);
            if (if_valid === 1'b1) got = 1'b1;
        end
        chk("restart_seen", 32'(got), 32'd1);
        if (got) chk("restart_pc", if_pc, 32'h0);

        // random traffic: stalls, redirects (incl. near the wrap point), grant gaps, latency 1..4
        gnt_pct = 70; lat_min = 1; lat_max = 4;
        l0 = loads;
        for (int k = 0; k < 2000; k++) begin
            logic        en_r, br_r;
            logic [31:0] tgt_r;
            en_r  = ($urandom_range(99) < 80);
            br_r  = ($urandom_range(99) < 5);
            tgt_r = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            step(en_r, br_r, tgt_r);
        end
        chk("random_progress", 32'(loads - l0 >= 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
